// File: rtl/llsc_ctrl.sv
// LL/SC link-state sequencer between MEM and the LLbit register: resolves SC, drives the WB-stage LLbit write.
// Optional macro LLSC_SNOOP_EN: conflicting local/external stores to the linked word break the link.
module llsc_ctrl #(
    parameter int LINK_TIMEOUT = 1024,
    parameter int ADDR_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              mem_stall,
    input  logic              mem_valid,
    input  logic              mem_op_ll,
    input  logic              mem_op_sc,
    input  logic              mem_op_st,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              ext_st_valid,
    input  logic [ADDR_W-1:0] ext_st_addr,
    input  logic              llbit_q,
    output logic              sc_success,
    output logic [31:0]       sc_result,
    output logic              llbit_we,
    output logic              llbit_wdata,
    output logic [ADDR_W-3:0] link_addr,
    output logic              linked
);

    localparam int CNT_W = (LINK_TIMEOUT > 0) ? $clog2(LINK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = (LINK_TIMEOUT > 0) ? CNT_W'(LINK_TIMEOUT - 1) : {CNT_W{1'b0}};

    typedef enum logic [0:0] {
        ST_UNLINKED = 1'b0,
        ST_LINKED   = 1'b1
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [ADDR_W-3:0] link_addr_r, link_addr_nxt_s;
    logic              llbit_we_r, llbit_we_nxt_s;
    logic              llbit_wdata_r, llbit_wdata_nxt_s;

    logic commit_s;
    logic ll_commit_s;
    logic sc_commit_s;
    logic eff_llbit_s;
    logic snoop_hit_s;
    logic timeout_s;

    assign commit_s    = mem_valid & ~mem_stall & ~flush;
    assign ll_commit_s = commit_s & mem_op_ll;
    assign sc_commit_s = commit_s & mem_op_sc;
    // A write still sitting in WB has not reached llbit_q yet, so forward it.
    assign eff_llbit_s = llbit_we_r ? llbit_wdata_r : llbit_q;
    assign timeout_s   = (LINK_TIMEOUT > 0) && (state_r == ST_LINKED) && (cnt_r == CNT_LAST);

`ifdef LLSC_SNOOP_EN
    logic unused_s;
    assign unused_s    = ^{mem_addr[1:0], ext_st_addr[1:0]};
    assign snoop_hit_s = (state_r == ST_LINKED) &&
                         ((commit_s && mem_op_st && (mem_addr[ADDR_W-1:2] == link_addr_r)) ||
                          (ext_st_valid && (ext_st_addr[ADDR_W-1:2] == link_addr_r)));
`else
    logic unused_s;
    assign unused_s    = ^{mem_addr[1:0], ext_st_addr, ext_st_valid, mem_op_st};
    assign snoop_hit_s = 1'b0;
`endif

    // Next-state selection in priority order: flush, committed LL/SC, snoop, timeout.
    always_comb begin
        state_nxt_s       = state_r;
        link_addr_nxt_s   = link_addr_r;
        llbit_we_nxt_s    = 1'b0;
        llbit_wdata_nxt_s = llbit_wdata_r;
        if ((state_r == ST_LINKED) && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end

        if (flush) begin
            state_nxt_s = ST_UNLINKED;
        end else if (ll_commit_s) begin
            state_nxt_s       = ST_LINKED;
            link_addr_nxt_s   = mem_addr[ADDR_W-1:2];
            cnt_nxt_s         = {CNT_W{1'b0}};
            llbit_we_nxt_s    = 1'b1;
            llbit_wdata_nxt_s = 1'b1;
        end else if (sc_commit_s || snoop_hit_s || timeout_s) begin
            state_nxt_s       = ST_UNLINKED;
            llbit_we_nxt_s    = 1'b1;
            llbit_wdata_nxt_s = 1'b0;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, counter, link address and WB-stage LLbit write registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_UNLINKED;
            cnt_r         <= {CNT_W{1'b0}};
            link_addr_r   <= {(ADDR_W-2){1'b0}};
            llbit_we_r    <= 1'b0;
            llbit_wdata_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            link_addr_r   <= link_addr_nxt_s;
            llbit_we_r    <= llbit_we_nxt_s;
            llbit_wdata_r <= llbit_wdata_nxt_s;
        end
    end

    assign sc_success  = ~reset & mem_valid & mem_op_sc & eff_llbit_s & ~flush;
    assign sc_result   = {31'b0, sc_success};
    assign llbit_we    = llbit_we_r;
    assign llbit_wdata = llbit_wdata_r;
    assign link_addr   = link_addr_r;
    assign linked      = (state_r == ST_LINKED);

endmodule

// File: doc/llsc_ctrl.md
# llsc_ctrl

Sequencing controller for the load-linked / store-conditional link state, sitting between the MEM stage and the LLbit register. It resolves LL/SC instructions in MEM, produces the SC result value, and drives the LLbit register write port one cycle later in the WB stage. It forwards any pending WB write so back-to-back LL/SC resolve correctly. It tracks the linked word address and breaks the link on flush, successful SC, link timeout and, optionally, conflicting stores.

## Interface
- LINK_TIMEOUT, 1024: cycles a link may stay LINKED before forced unlink; 0 disables the timeout.
- ADDR_W, 32: byte address width.

- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high (`ResetEnable`); clears all state on the next posedge.
- flush  in  1  pipeline flush (exception/eret); kills the link and any MEM-stage op this cycle.
- mem_stall  in  1  MEM stage held; the MEM op is not committed this cycle.
- mem_valid  in  1  MEM stage holds a valid instruction.
- mem_op_ll  in  1  MEM instruction is LL.
- mem_op_sc  in  1  MEM instruction is SC.
- mem_op_st  in  1  MEM instruction is an ordinary store (SB/SH/SW/SWL/SWR).
- mem_addr  in  ADDR_W  MEM effective address.
- ext_st_valid  in  1  store by another bus master this cycle.
- ext_st_addr  in  ADDR_W  address of that store.
- llbit_q  in  1  current LLbit register output.
- sc_success  out  1  combinational: SC in MEM will write memory.
- sc_result  out  32  combinational: {31'b0, sc_success}; written to rt.
- llbit_we  out  1  registered LLbit write enable (WB stage).
- llbit_wdata  out  1  registered LLbit write value.
- link_addr  out  ADDR_W-2  linked word address (addr[ADDR_W-1:2]).
- linked  out  1  state == LINKED.

## Operation
- States: UNLINKED, LINKED. Reset: UNLINKED, counter 0, link_addr 0, llbit_we 0, llbit_wdata 0. sc_success and sc_result are 0 while reset is asserted.
- The op is committed when `mem_valid & ~mem_stall & ~flush`.
- eff_llbit = llbit_we ? llbit_wdata : llbit_q (WB forwarding).
- sc_success = mem_valid & mem_op_sc & eff_llbit & ~flush.
- Committed LL: link_addr <= mem_addr[ADDR_W-1:2]; state <= LINKED; counter <= 0; llbit_we/wdata <= 1/1.
- Committed SC, success or fail: state <= UNLINKED; llbit_we/wdata <= 1/0.
- Flush: state <= UNLINKED; llbit_we <= 0. Any MEM op is discarded. The LLbit register itself clears on flush.
- Timeout (LINK_TIMEOUT>0): in LINKED, counter increments each cycle. When counter == LINK_TIMEOUT-1: state <= UNLINKED; llbit_we/wdata <= 1/0.
- No event: llbit_we <= 0.
- Priority: reset > flush > committed LL/SC > snoop unlink > timeout.
- Counter width: clog2(LINK_TIMEOUT+1). The counter saturates and never wraps.

## Timing
- MEM op in cycle N produces the LLbit write in cycle N+1. LLbit_q reflects it at N+2.
- Back-to-back LL (N), SC (N+1): SC sees eff_llbit=1 via forwarding. sc_success=1 in N+1.
- SC (N), SC (N+1): the second SC fails (forwarded 0).
- Stall: the decision is held combinationally. No state change until the stall releases.
- Reset mid-link: UNLINKED next cycle, no LLbit write issued.

## Configuration
- LLSC_SNOOP_EN defined: while LINKED, either of the following unlinks the block (state <= UNLINKED, llbit_we/wdata <= 1/0):
  - a committed ordinary store with mem_addr[ADDR_W-1:2] == link_addr;
  - ext_st_valid with ext_st_addr[ADDR_W-1:2] == link_addr.
- A committed LL in the same cycle wins over the snoop and relinks.
- Undefined: ext_st_* and mem_op_st are ignored. The link breaks only via SC, flush, timeout or reset.

## Test plan
- Reset asserted 2 cycles: linked=0, llbit_we=0, llbit_wdata=0, sc_result=0, link_addr=0.
- LL @0x1004 at cycle N, SC @0x1004 at N+1: sc_success=1, sc_result=0x1 at N+1; llbit_we/wdata=1/1 at N+1, 1/0 at N+2; linked=0 at N+2.
- LL at N, flush at N+2, SC at N+3: sc_success=0, sc_result=0x0, no llbit write.
- LINK_TIMEOUT=4, LL at N, idle: linked drops at N+5 with llbit_we/wdata=1/0 at N+5. A later SC fails.
- With LLSC_SNOOP_EN: LL @0x2000, ext_st @0x2002: unlink, SC fails. Ext store @0x2004 does not unlink, SC succeeds. Without the macro, both SCs succeed.
- SC with mem_stall=1 for 3 cycles then released: sc_success stable at 1 throughout; exactly one llbit_we pulse, in the cycle after release.
